// File: rtl/bounce_seq_checker_if.sv
// ---------------------------------------------------------------------------
// bounce_seq_checker_if
//   Bundles the sample stream and the status outputs of the bounce-sequence
//   checker.
//   master : stream source / status consumer (drives clear, sample_valid,
//            sample; reads the status outputs)
//   slave  : the checker itself
//   Signals:
//     clear         zero err_count and period_count (synchronous)
//     sample_valid  a sample is present this cycle
//     sample        observed counter value, W bits
//     locked        checker is locked onto the stream
//     dir           predicted direction, 0 = up, 1 = down
//     expected      predicted value of the next valid sample
//     err           one-cycle pulse per mismatching sample while locked
//     err_count     saturating error count
//     period_count  completed triangle periods, wrapping
// ---------------------------------------------------------------------------
interface bounce_seq_checker_if #(
   parameter int W = 4
) ();
   logic         clear;
   logic         sample_valid;
   logic [W-1:0] sample;
   logic         locked;
   logic         dir;
   logic [W-1:0] expected;
   logic         err;
   logic [7:0]   err_count;
   logic [7:0]   period_count;

   modport master (
      output clear, sample_valid, sample,
      input  locked, dir, expected, err, err_count, period_count
   );

   modport slave (
      input  clear, sample_valid, sample,
      output locked, dir, expected, err, err_count, period_count
   );
endinterface

// File: rtl/bounce_seq_checker.sv
// ---------------------------------------------------------------------------
// bounce_seq_checker
//   Receive-side monitor for the W-bit up/down triangle counter stream
//   0,1,..,MAX,MAX-1,..,0,1,..  It acquires the stream, locks onto its phase
//   and direction, then predicts every next value, flags and counts
//   deviations and counts completed periods.
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-high; clears all state
//     bus    bounce_seq_checker_if.slave (sample stream in, status out)
//   'dir' is always the direction of the step that produces 'expected', so
//   next(expected, dir) is the prediction one step further on.
// ---------------------------------------------------------------------------
module bounce_seq_checker #(
   parameter int W          = 4,
   parameter int LOCK_LEN   = 3,
   parameter int UNLOCK_LEN = 2
) (
   input logic                  clock,
   input logic                  reset,
   bounce_seq_checker_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

   typedef struct packed {
      logic [W-1:0] v;
      logic         d;
   } step_t;

   localparam logic [W-1:0] MAX      = '1;
   localparam logic [3:0]   LOCK_N   = 4'(LOCK_LEN);
   localparam logic [3:0]   UNLOCK_N = 4'(UNLOCK_LEN);

   // One step of the triangle: turn around at MAX and at 0, never wrap.
   function automatic step_t next_step(input logic [W-1:0] v, input logic d);
      step_t r;
      if (!d) begin
         if (v == MAX) begin
            r.v = MAX - W'(1);
            r.d = 1'b1;
         end else begin
            r.v = v + W'(1);
            r.d = 1'b0;
         end
      end else begin
         if (v == '0) begin
            r.v = W'(1);
            r.d = 1'b0;
         end else begin
            r.v = v - W'(1);
            r.d = 1'b1;
         end
      end
      return r;
   endfunction

   state_t       state, state_n;
   logic [W-1:0] last_q, last_n;
   logic [3:0]   match_q, match_n;
   logic [3:0]   miss_q, miss_n;
   logic         dir_q, dir_n;
   logic [W-1:0] exp_q, exp_n;
   logic         err_q, err_n;
   logic [7:0]   ec_q, ec_n;
   logic [7:0]   pc_q, pc_n;

   step_t        s_fwd, s_alt, s_fly, s_pred;
   logic         dir_pick;

   // State register (FSM state plus the datapath registers it steers).
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         last_q  <= '0;
         match_q <= '0;
         miss_q  <= '0;
         dir_q   <= 1'b0;
         exp_q   <= '0;
         err_q   <= 1'b0;
         ec_q    <= '0;
         pc_q    <= '0;
      end else begin
         state   <= state_n;
         last_q  <= last_n;
         match_q <= match_n;
         miss_q  <= miss_n;
         dir_q   <= dir_n;
         exp_q   <= exp_n;
         err_q   <= err_n;
         ec_q    <= ec_n;
         pc_q    <= pc_n;
      end
   end

   // Next-state and datapath update.
   // NOTE: every variable gets a default at the top of the block; a path
   // that forgot one would otherwise infer a latch.
   always_comb begin
      state_n  = state;
      last_n   = last_q;
      match_n  = match_q;
      miss_n   = miss_q;
      dir_n    = dir_q;
      exp_n    = exp_q;
      err_n    = 1'b0;
      ec_n     = ec_q;
      pc_n     = pc_q;
      dir_pick = dir_q;
      s_fwd    = next_step(last_q, dir_q);
      s_alt    = next_step(last_q, ~dir_q);
      s_fly    = next_step(exp_q, dir_q);
      s_pred   = '0;

      if (bus.sample_valid) begin
         unique case (state)
            IDLE: begin
               last_n  = bus.sample;
               match_n = '0;
               state_n = ACQ;
            end

            ACQ: begin
               // Prefer the current candidate direction; fall back to the
               // opposite one, which restarts the consistency run at 1.
               if (bus.sample == s_fwd.v) begin
                  match_n  = match_q + 4'd1;
                  dir_pick = s_fwd.d;
               end else if (bus.sample == s_alt.v) begin
                  match_n  = 4'd1;
                  dir_pick = s_alt.d;
               end else begin
                  match_n  = '0;
               end
               s_pred = next_step(bus.sample, dir_pick);
               exp_n  = s_pred.v;
               dir_n  = s_pred.d;
               last_n = bus.sample;
               if (match_n == LOCK_N) begin
                  state_n = LOCKED;
                  miss_n  = '0;
               end
            end

            LOCKED: begin
               // Flywheel: the prediction always advances from itself and is
               // never resynced to a bad sample.
               exp_n = s_fly.v;
               dir_n = s_fly.d;
               if (bus.sample == exp_q) begin
                  miss_n = '0;
                  if (bus.sample == '0 && dir_q)
                     pc_n = pc_q + 8'd1;
               end else begin
                  err_n  = 1'b1;
                  miss_n = miss_q + 4'd1;
                  if (ec_q != 8'hFF)
                     ec_n = ec_q + 8'd1;
                  if (miss_n == UNLOCK_N) begin
                     state_n = ACQ;
                     last_n  = bus.sample;
                     match_n = '0;
                  end
               end
            end

            default: state_n = IDLE;
         endcase
      end

      // Clear overrides any same-cycle increment; err itself still pulses.
      if (bus.clear) begin
         ec_n = '0;
         pc_n = '0;
      end
   end

   // Outputs.
   always_comb begin
      bus.locked       = (state == LOCKED);
      bus.dir          = dir_q;
      bus.expected     = exp_q;
      bus.err          = err_q;
      bus.err_count    = ec_q;
      bus.period_count = pc_q;
   end

endmodule
